// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers at BASE_ADDR.
// Write address and data are captured independently and committed together; reads return in one cycle.
module axi_lite_reg_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           i_axi_awvalid,
  output logic                           o_axi_awready,
  input  logic [ADDR_WIDTH-1:0]          i_axi_awaddr,
  input  logic [2:0]                     i_axi_awprot,
  input  logic                           i_axi_wvalid,
  output logic                           o_axi_wready,
  input  logic [DATA_WIDTH-1:0]          i_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        i_axi_wstrb,
  output logic                           o_axi_bvalid,
  input  logic                           i_axi_bready,
  input  logic                           i_axi_arvalid,
  output logic                           o_axi_arready,
  input  logic [ADDR_WIDTH-1:0]          i_axi_araddr,
  input  logic [2:0]                     i_axi_arprot,
  output logic                           o_axi_rvalid,
  input  logic                           i_axi_rready,
  output logic [DATA_WIDTH-1:0]          o_axi_rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);

  localparam int                    IDX_W  = $clog2(NUM_REGS);
  localparam int                    STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] SPAN   = ADDR_WIDTH'(NUM_REGS * 4);

  // Handshake rule: a beat transfers on a rising edge where valid && ready are both 1.
  logic                  init_q, init_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0] aw_off, ar_off;
  logic                  aw_hit, ar_hit;
  logic [IDX_W-1:0]      aw_idx, ar_idx;
  logic                  unused_prot;

  assign unused_prot = ^{i_axi_awprot, i_axi_arprot};

  // init_q keeps all readies low in reset and for the cycle in which reset is released.
  assign o_axi_awready = init_q && !aw_done_q && !bvalid_q;
  assign o_axi_wready  = init_q && !w_done_q && !bvalid_q;
  assign o_axi_arready = init_q && !rvalid_q;
  assign o_axi_bvalid  = bvalid_q;
  assign o_axi_rvalid  = rvalid_q;
  assign o_axi_rdata   = rdata_q;

  assign aw_hs = i_axi_awvalid && o_axi_awready;
  assign w_hs  = i_axi_wvalid && o_axi_wready;
  assign ar_hs = i_axi_arvalid && o_axi_arready;

  assign aw_off = awaddr_q - BASE_ADDR;
  assign ar_off = i_axi_araddr - BASE_ADDR;
  assign aw_hit = aw_off < SPAN;
  assign ar_hit = ar_off < SPAN;
  assign aw_idx = aw_off[IDX_W+1:2];
  assign ar_idx = ar_off[IDX_W+1:2];

  always_comb begin
    init_d    = 1'b1;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    regs_d    = regs_q;

    if (aw_hs) begin
      aw_done_d = 1'b1;
      awaddr_d  = i_axi_awaddr;
    end
    if (w_hs) begin
      w_done_d = 1'b1;
      wdata_d  = i_axi_wdata;
      wstrb_d  = i_axi_wstrb;
    end

    if (bvalid_q && i_axi_bready) begin
      bvalid_d = 1'b0;
    end
    // Both halves captured: the commit happens here, so a same-edge read still sees regs_q.
    if (aw_done_q && w_done_q) begin
      if (aw_hit) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb_q[b]) begin
            regs_d[aw_idx][8*b +: 8] = wdata_q[8*b +: 8];
          end
        end
      end
      bvalid_d  = 1'b1;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end

    if (rvalid_q && i_axi_rready) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_hit ? regs_q[ar_idx] : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      init_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      regs_q    <= '{default: '0};
    end else begin
      init_q    <= init_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: directed scenarios plus random traffic, checked every
// cycle against a transaction-level register model.
module tb_axi_lite_reg_slave;

  localparam int          NR   = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic          bready = 1'b0, rready = 1'b0;
  logic [31:0]   awaddr = '0, araddr = '0, wdata = '0;
  logic [3:0]    wstrb = '0;
  logic [2:0]    awprot = 3'd0, arprot = 3'd0;
  logic          awready, wready, arready, bvalid, rvalid;
  logic [31:0]   rdata;
  logic [NR*32-1:0] regs_flat;

  axi_lite_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .i_axi_awvalid(awvalid), .o_axi_awready(awready), .i_axi_awaddr(awaddr), .i_axi_awprot(awprot),
    .i_axi_wvalid(wvalid), .o_axi_wready(wready), .i_axi_wdata(wdata), .i_axi_wstrb(wstrb),
    .o_axi_bvalid(bvalid), .i_axi_bready(bready),
    .i_axi_arvalid(arvalid), .o_axi_arready(arready), .i_axi_araddr(araddr), .i_axi_arprot(arprot),
    .o_axi_rvalid(rvalid), .i_axi_rready(rready), .o_axi_rdata(rdata),
    .o_regs(regs_flat)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit rand_rdy = 1'b0;
  bit b_force  = 1'b1;
  bit r_force  = 1'b1;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin n_fail++; $display("FAIL %s: got %0b expected %0b @%0t", name, act, exp, $time); end
  endtask
  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin n_fail++; $display("FAIL %s: got %08h expected %08h @%0t", name, act, exp, $time); end
  endtask
  task automatic chk_r(input string name, input logic [NR*32-1:0] act, input logic [NR*32-1:0] exp);
    n_checks++;
    if (act !== exp) begin n_fail++; $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time); end
  endtask
  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout waiting for handshake @%0t", name, $time);
  endtask

  // Response readies: driven late in the cycle so driver tasks can set b_force/r_force first.
  initial forever begin
    @(posedge clk);
    #2;
    if (rand_rdy) begin
      bready = ($urandom_range(0, 3) != 0);
      rready = ($urandom_range(0, 3) != 0);
    end else begin
      bready = b_force;
      rready = r_force;
    end
  end

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [NR];
  bit          m_init, m_aw, m_w, m_b, m_r;
  logic [31:0] m_awaddr, m_wdata, m_hold;
  logic [3:0]  m_wstrb;
  logic [31:0] exp_q[$];

  function automatic bit m_decode(input logic [31:0] a, output int idx);
    logic [31:0] off;
    off = a - BASE;
    idx = int'(off / 4);
    return off < NR * 4;
  endfunction

  initial begin
    m_init = 0; m_aw = 0; m_w = 0; m_b = 0; m_r = 0;
    m_awaddr = '0; m_wdata = '0; m_wstrb = '0; m_hold = '0;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        m_init = 0; m_aw = 0; m_w = 0; m_b = 0; m_r = 0; m_hold = '0;
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        exp_q.delete();
      end else begin
        bit aw_hs, w_hs, ar_hs, r_hs, commit;
        int idx;
        logic [31:0] rd;
        aw_hs  = awvalid && m_init && !m_aw && !m_b;
        w_hs   = wvalid && m_init && !m_w && !m_b;
        ar_hs  = arvalid && m_init && !m_r;
        r_hs   = m_r && rready;
        commit = m_aw && m_w;
        rd = m_decode(araddr, idx) ? m_regs[idx] : 32'h0;
        if (m_b && bready) m_b = 0;
        if (commit) begin
          if (m_decode(m_awaddr, idx))
            for (int b = 0; b < 4; b++)
              if (m_wstrb[b]) m_regs[idx][8*b +: 8] = m_wdata[8*b +: 8];
          m_b = 1; m_aw = 0; m_w = 0;
        end
        if (aw_hs) begin m_aw = 1; m_awaddr = awaddr; end
        if (w_hs) begin m_w = 1; m_wdata = wdata; m_wstrb = wstrb; end
        if (r_hs) begin m_r = 0; if (exp_q.size() > 0) m_hold = exp_q.pop_front(); end
        if (ar_hs) begin m_r = 1; exp_q.push_back(rd); end
        m_init = 1;
      end
    end
  end

  // ---------------- scoreboard: compare every cycle ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      logic [NR*32-1:0] exp_flat;
      logic [31:0]      exp_rd;
      for (int i = 0; i < NR; i++) exp_flat[i*32 +: 32] = m_regs[i];
      exp_rd = (m_r && exp_q.size() > 0) ? exp_q[0] : m_hold;
      chk_b("awready", awready, m_init && !m_aw && !m_b);
      chk_b("wready", wready, m_init && !m_w && !m_b);
      chk_b("arready", arready, m_init && !m_r);
      chk_b("bvalid", bvalid, m_b);
      chk_b("rvalid", rvalid, m_r);
      chk_w("rdata", rdata, exp_rd);
      chk_r("o_regs", regs_flat, exp_flat);
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic do_reset();
    awvalid = 0; wvalid = 0; arvalid = 0;
    resetn = 0;
    @(negedge clk);
    chk_b("rst_awready", awready, 1'b0);
    chk_b("rst_arready", arready, 1'b0);
    chk_w("rst_rdata", rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    chk_b("rel_wready_low", wready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_b("rel_awready_high", awready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic do_aw(input logic [31:0] a);
    bit ok;
    int n = 0;
    awaddr = a; awvalid = 1;
    do begin
      @(negedge clk); ok = awready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 200);
    if (!ok) timeout("aw");
    awvalid = 0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    bit ok;
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1;
    do begin
      @(negedge clk); ok = wready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 200);
    if (!ok) timeout("w");
    wvalid = 0;
  endtask

  task automatic wait_b();
    bit ok;
    int n = 0;
    do begin
      @(negedge clk); ok = bvalid && bready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 200);
    if (!ok) timeout("b");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int da, input int dw);
    fork
      begin repeat (da) begin @(posedge clk); #1; end do_aw(a); end
      begin repeat (dw) begin @(posedge clk); #1; end do_w(d, s); end
    join
    wait_b();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    bit ok;
    int n = 0;
    araddr = a; arvalid = 1;
    do begin
      @(negedge clk); ok = arready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 200);
    if (!ok) timeout("ar");
    arvalid = 0;
    n = 0;
    d = '0;
    do begin
      @(negedge clk); ok = rvalid && rready; d = rdata;
      @(posedge clk); #1; n++;
    end while (!ok && n < 200);
    if (!ok) timeout("r");
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < NR) return BASE + 32'(r * 4) + 32'($urandom_range(0, 3));
    if (r == NR) return BASE + 32'(NR * 4);
    return BASE - 32'd4;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    logic [NR*32-1:0] snap;
    #1;
    chk_en = 1'b1;
    do_reset();

    // Staggered AW then W three cycles later.
    awaddr = BASE + 32'h4; awvalid = 1;
    @(posedge clk); #1 awvalid = 0;
    repeat (2) begin @(posedge clk); #1; end
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1;
    @(posedge clk); #1 wvalid = 0;
    @(negedge clk); chk_b("b_not_yet", bvalid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); chk_b("b_rise", bvalid, 1'b1);
    chk_w("reg1_write", regs_flat[32 +: 32], 32'hDEAD_BEEF);
    @(posedge clk); #1;
    do_read(BASE + 32'h4, rd);
    chk_w("reg1_read", rd, 32'hDEAD_BEEF);

    // Same-cycle AW/W with partial strobes.
    do_write(BASE + 32'h8, 32'h1111_1111, 4'hF, 0, 0);
    do_write(BASE + 32'h8, 32'hABCD_FFFF, 4'b0101, 0, 0);
    chk_w("reg2_strb", regs_flat[64 +: 32], 32'h11CD_11FF);
    do_write(BASE + 32'h8, 32'h0000_0000, 4'h0, 1, 0);
    chk_w("reg2_strb0", regs_flat[64 +: 32], 32'h11CD_11FF);

    // Response backpressure.
    b_force = 0;
    fork do_aw(BASE + 32'h14); do_w(32'h5555_AAAA, 4'hF); join
    for (int n = 0; n < 50 && !bvalid; n++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk_b("bp_bvalid", bvalid, 1'b1);
      chk_b("bp_awready", awready, 1'b0);
      chk_b("bp_wready", wready, 1'b0);
      @(negedge clk);
    end
    b_force = 1;
    @(posedge clk); #3;
    @(negedge clk); chk_b("bp_hold", bvalid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk_b("bp_clear", bvalid, 1'b0);
    chk_b("bp_awready_back", awready, 1'b1);
    @(posedge clk); #1;

    // Miss write and miss read.
    snap = regs_flat;
    do_write(32'h2000_0000, 32'h1234_5678, 4'hF, 0, 2);
    chk_r("miss_regs", regs_flat, snap);
    do_read(32'h2000_0000, rd);
    chk_w("miss_read", rd, 32'h0);
    do_read(BASE + 32'(NR * 4), rd);
    chk_w("miss_past_end", rd, 32'h0);

    // Commit and AR on the same edge to reg3.
    do_reset();
    awaddr = BASE + 32'hC; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = BASE + 32'hC;
    @(posedge clk); #1 awvalid = 0; wvalid = 0; arvalid = 1;
    @(posedge clk); #1 arvalid = 0;
    @(negedge clk);
    chk_b("race_rvalid", rvalid, 1'b1);
    chk_w("race_rdata_old", rdata, 32'h0);
    chk_w("race_reg3_new", regs_flat[96 +: 32], 32'hFFFF_FFFF);
    @(posedge clk); #1;
    do_read(BASE + 32'hC, rd);
    chk_w("race_reg3_read", rd, 32'hFFFF_FFFF);

    // Reset in the middle of pending transactions.
    do_write(BASE, 32'hCAFE_F00D, 4'hF, 0, 0);
    r_force = 0;
    araddr = BASE; arvalid = 1;
    @(posedge clk); #1 arvalid = 0;
    awaddr = BASE + 32'h4; awvalid = 1;
    @(posedge clk); #1 awvalid = 0;
    #2 resetn = 0;
    #1;
    chk_b("mid_rst_rvalid", rvalid, 1'b0);
    chk_b("mid_rst_bvalid", bvalid, 1'b0);
    chk_b("mid_rst_awready", awready, 1'b0);
    chk_b("mid_rst_arready", arready, 1'b0);
    chk_w("mid_rst_rdata", rdata, 32'h0);
    chk_r("mid_rst_regs", regs_flat, '0);
    @(posedge clk); #1 resetn = 1; r_force = 1;
    @(posedge clk); #1;
    do_w(32'h7777_7777, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk_b("mid_rst_no_b", bvalid, 1'b0);
    end
    @(posedge clk); #1;

    // Random concurrent traffic.
    do_reset();
    rand_rdy = 1'b1;
    fork
      for (int i = 0; i < 150; i++)
        do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      for (int i = 0; i < 150; i++) begin
        logic [31:0] d;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        do_read(rand_addr(), d);
      end
    join
    rand_rdy = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    for (int i = 0; i < NR; i++) do_read(BASE + 32'(i * 4), rd);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_slave.md
AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, address bus width.
REQ-002 Parameter: DATA_WIDTH, 32, data bus width; fixed at 32 for this block.
REQ-003 Parameter: NUM_REGS, 8, number of 32-bit registers; power of two, minimum 2.
REQ-004 Parameter: BASE_ADDR, 32'h1000_0000, byte address of register 0; aligned to NUM_REGS*4.
REQ-005 Ports shall be, clock and reset first:
  clk  in  1  single clock; all state changes on its rising edge
  resetn  in  1  asynchronous, active-low reset
  i_axi_awvalid  in  1  write address valid (from arbiter o_s_axi_awvalid)
  o_axi_awready  out  1  write address ready
  i_axi_awaddr  in  ADDR_WIDTH  write byte address
  i_axi_awprot  in  3  protection; accepted, ignored
  i_axi_wvalid  in  1  write data valid
  o_axi_wready  out  1  write data ready
  i_axi_wdata  in  DATA_WIDTH  write data
  i_axi_wstrb  in  DATA_WIDTH/8  byte enables
  o_axi_bvalid  out  1  write response valid
  i_axi_bready  in  1  write response ready
  i_axi_arvalid  in  1  read address valid
  o_axi_arready  out  1  read address ready
  i_axi_araddr  in  ADDR_WIDTH  read byte address
  i_axi_arprot  in  3  protection; accepted, ignored
  o_axi_rvalid  out  1  read data valid
  i_axi_rready  in  1  read data ready
  o_axi_rdata  out  DATA_WIDTH  read data
  o_regs  out  NUM_REGS*DATA_WIDTH  flat register contents, reg 0 in LSBs

Function
REQ-006 Address decode: offset = addr - BASE_ADDR; hit when offset < NUM_REGS*4; index = offset[log2(NUM_REGS)+1:2]; addr[1:0] ignored.
REQ-007 Write path: independent AW and W capture flags, aw_done and w_done; the two may arrive in either order or in the same cycle.
REQ-008 o_axi_awready = !aw_done && !o_axi_bvalid; o_axi_wready = !w_done && !o_axi_bvalid; both combinational from registered state only.
REQ-009 AW handshake latches awaddr and sets aw_done; W handshake latches wdata/wstrb and sets w_done.
REQ-010 On the first edge where aw_done && w_done: commit write, set o_axi_bvalid=1, clear both flags. bvalid appears one cycle after the later handshake.
REQ-011 Commit: for each byte b with wstrb[b]=1, reg[index][8b+7:8b] <= wdata byte b; wstrb=0 leaves reg unchanged; miss address leaves all regs unchanged.
REQ-012 o_axi_bvalid holds until i_axi_bready=1 at an edge, then clears. No new AW/W is accepted while bvalid=1.
REQ-013 Read path: o_axi_arready = !o_axi_rvalid.
REQ-014 AR handshake: o_axi_rdata <= reg[index] on hit, 32'h0 on miss; o_axi_rvalid <= 1 at the same edge (latency 1 cycle).
REQ-015 o_axi_rvalid and o_axi_rdata hold stable until i_axi_rready=1 at an edge; rvalid then clears. Back-to-back reads: one per 2 cycles maximum.
REQ-016 Read and write paths are fully independent and may handshake in the same cycle.
REQ-017 Same-edge write commit and AR handshake to the same register: rdata returns the pre-write value.
REQ-018 o_regs reflects register contents continuously from flops, updated at the commit edge.
REQ-019 Valid inputs deasserted before handshake (protocol violation) shall not corrupt state; no capture occurs without valid&&ready.

Reset
REQ-020 resetn=0 asynchronously clears: all registers to 0, aw_done, w_done, o_axi_bvalid, o_axi_rvalid, o_axi_rdata to 0.
REQ-021 During reset o_axi_awready, o_axi_wready, o_axi_arready shall be 0; they rise on the first clock edge after resetn=1 sample.
REQ-022 Reset asserted mid-transaction (flag set or bvalid/rvalid pending) discards the transaction; no partial register write occurs.

Verification
REQ-023 AW 0x1000_0004 then W 0xDEAD_BEEF strb 4'hF three cycles later -> bvalid rises one cycle after W handshake; reg[1]=0xDEAD_BEEF; read 0x1000_0004 returns 0xDEAD_BEEF.
REQ-024 AW and W same cycle, addr 0x1000_0008, data 0xABCD_FFFF, strb 4'b0101, reg[2] previously 0x1111_1111 -> reg[2]=0x11CD_11FF.
REQ-025 bready held low 5 cycles after bvalid -> bvalid stays 1, awready/wready stay 0; bready=1 -> bvalid clears next edge, awready returns.
REQ-026 Write 0x1234_5678 to 0x2000_0000 (miss) -> bvalid issued, o_regs unchanged; read 0x2000_0000 -> rdata 0x0000_0000.
REQ-027 Write commit to reg[3] (old 0x0, new 0xFFFF_FFFF) on same edge as AR to 0x1000_000C -> rdata 0x0; subsequent read -> 0xFFFF_FFFF.
REQ-028 resetn pulsed low with aw_done=1 and rvalid=1 -> all outputs 0 immediately, o_regs all 0, no bvalid after release.
